// File: rtl/icache_refill_axi.sv
// I-cache line-refill engine: one AXI read burst per miss and one full-line response,
// with an optional critical-word-first WRAP burst and an early critical-word pulse.
`timescale 1ns/1ps
module icache_refill_axi #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 40,
    parameter int DATA_WIDTH     = 32,
    parameter int LINE_WORDS     = 8,
    parameter bit WRAP_BURST     = 1'b0
) (
    input  logic                             cpu_clk,
    input  logic                             cpu_reset,
    input  logic                             refill_req_valid,
    input  logic [ADDR_WIDTH-1:0]            refill_req_addr,
    output logic                             refill_req_ready,
    output logic                             refill_crit_valid,
    output logic [DATA_WIDTH-1:0]            refill_crit_word,
    output logic                             refill_rsp_valid,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] refill_rsp_line,
    output logic                             refill_rsp_err,
    input  logic                             refill_rsp_ready,
    output logic [AXI_ADDR_WIDTH-1:0]        cpu_inst_araddr,
    output logic                             cpu_inst_arvalid,
    input  logic                             cpu_inst_arready,
    output logic [2:0]                       cpu_inst_arsize,
    output logic [1:0]                       cpu_inst_arburst,
    output logic [7:0]                       cpu_inst_arlen,
    input  logic [DATA_WIDTH-1:0]            cpu_inst_rdata,
    input  logic [1:0]                       cpu_inst_rresp,
    input  logic                             cpu_inst_rvalid,
    input  logic                             cpu_inst_rlast,
    output logic                             cpu_inst_rready
);
    localparam int WB        = $clog2(DATA_WIDTH / 8);
    localparam int IW        = $clog2(LINE_WORDS);
    localparam int LB        = WB + IW;
    localparam int CW        = IW + 1;
    localparam int LINE_BITS = LINE_WORDS * DATA_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LOW_MASK =
        ADDR_WIDTH'((64'd1 << (WRAP_BURST ? WB : LB)) - 64'd1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, AR, R, RSP} state_t;
    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [IW-1:0]         req_idx_q;
    logic [CW-1:0]         cnt_q;
    logic                  err_q;
    logic [LINE_BITS-1:0]  line_q;
    logic [DATA_WIDTH-1:0] crit_word_q;
    logic                  crit_valid_q;

    logic          req_fire;
    logic          beat;
    logic          last_beat;
    logic          beat_err;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] slot_idx;

    assign req_fire  = (state == IDLE) && refill_req_valid;
    assign beat      = (state == R) && cpu_inst_rvalid;
    assign last_beat = (cnt_q == LAST_CNT);
    assign beat_err  = (cpu_inst_rresp != 2'b00) || (cpu_inst_rlast != last_beat);
    // IW-bit addition wraps the slot index modulo LINE_WORDS for WRAP bursts.
    assign start_idx = WRAP_BURST ? req_idx_q : '0;
    assign slot_idx  = start_idx + cnt_q[IW-1:0];

    assign cpu_inst_araddr   = AXI_ADDR_WIDTH'(addr_q & ~LOW_MASK);
    assign cpu_inst_arsize   = 3'(WB);
    assign cpu_inst_arburst  = WRAP_BURST ? 2'b10 : 2'b01;
    assign cpu_inst_arlen    = 8'(LINE_WORDS - 1);
    assign refill_crit_valid = crit_valid_q;
    assign refill_crit_word  = crit_word_q;
    assign refill_rsp_line   = line_q;
    assign refill_rsp_err    = err_q;

    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) state <= IDLE;
        else           state <= state_next;
    end

    always_comb begin
        state_next       = state;
        refill_req_ready = 1'b0;
        cpu_inst_arvalid = 1'b0;
        cpu_inst_rready  = 1'b0;
        refill_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                refill_req_ready = 1'b1;
                if (refill_req_valid) state_next = AR;
            end
            AR: begin
                cpu_inst_arvalid = 1'b1;
                if (cpu_inst_arready) state_next = R;
            end
            R: begin
                cpu_inst_rready = 1'b1;
                if (cpu_inst_rvalid && (last_beat || cpu_inst_rlast)) state_next = RSP;
            end
            RSP: begin
                refill_rsp_valid = 1'b1;
                if (refill_rsp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Slots not written after an early rlast keep whatever the previous line left there.
    always_ff @(posedge cpu_clk or posedge cpu_reset) begin
        if (cpu_reset) begin
            addr_q       <= '0;
            req_idx_q    <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            line_q       <= '0;
            crit_word_q  <= '0;
            crit_valid_q <= 1'b0;
        end else begin
            crit_valid_q <= 1'b0;
            if (req_fire) begin
                addr_q    <= refill_req_addr;
                req_idx_q <= refill_req_addr[LB-1:WB];
                cnt_q     <= '0;
                err_q     <= 1'b0;
            end
            if (beat) begin
                line_q[slot_idx*DATA_WIDTH +: DATA_WIDTH] <= cpu_inst_rdata;
                cnt_q <= cnt_q + CW'(1);
                if (beat_err) err_q <= 1'b1;
                if (slot_idx == req_idx_q) begin
                    crit_word_q  <= cpu_inst_rdata;
                    crit_valid_q <= 1'b1;
                end
            end
        end
    end
endmodule
